// File: rtl/conv_pkg.sv
// Shared widths and FSM encoding for the 3x3x3 convolution MAC/ReLU stage.
// Pixels are unsigned bytes; weights and bias are signed bytes.
package conv_pkg;
  localparam int PIX_W    = 8;
  localparam int WT_W     = 8;
  localparam int PROD_W   = 17;
  localparam int ACC_W    = 24;
  localparam int NUM_TAPS = 9;
  localparam int NUM_CH   = 3;
  localparam int NUM_WTS  = NUM_TAPS * NUM_CH;
  localparam int WIN_W    = PIX_W * NUM_TAPS;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/conv3x3_mac_relu_mac9.sv
// One channel of the convolution: nine pixel x weight products (S1), then their sum (S2).
// The datapath is free-running; validity is tracked by the parent.
module mac9
  import conv_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [WIN_W-1:0]        i_pix,
  input  logic [WIN_W-1:0]        i_wt,
  output logic signed [ACC_W-1:0] o_sum
);
  logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_d [NUM_TAPS];
  logic signed [ACC_W-1:0]  sum_q, sum_d;

  // Pixel is zero-extended to 9b signed before the multiply so 255 stays positive.
  always_comb begin
    sum_d = '0;
    for (int p = 0; p < NUM_TAPS; p++) begin
      prod_d[p] = PROD_W'(signed'({1'b0, i_pix[PIX_W*p +: PIX_W]}))
                * PROD_W'(signed'(i_wt[WT_W*p +: WT_W]));
      sum_d     = sum_d + ACC_W'(prod_q[p]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int p = 0; p < NUM_TAPS; p++) prod_q[p] <= '0;
      sum_q <= '0;
    end else begin
      for (int p = 0; p < NUM_TAPS; p++) prod_q[p] <= prod_d[p];
      sum_q <= sum_d;
    end
  end

  assign o_sum = sum_q;
endmodule

// File: rtl/conv3x3_mac_relu.sv
// 3x3x3 convolution for one output channel: weight/bias load FSM, bias add, ReLU,
// requantising shift with saturation, and row/frame done pulses. Latency is 4 cycles.
// Handshake: no backpressure on windows; a weight byte is taken on any cycle where
// i_wt_valid is high while o_wt_ready is high.
module conv3x3_mac_relu
  import conv_pkg::*;
#(
  parameter int SHIFT    = 8,
  parameter int ROW_OUT  = 111,
  parameter int ROWS_OUT = 111
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIN_W-1:0] i_pixel_data1,
  input  logic [WIN_W-1:0] i_pixel_data2,
  input  logic [WIN_W-1:0] i_pixel_data3,
  input  logic             i_pixel_data_valid,
  input  logic [WT_W-1:0]  i_wt_data,
  input  logic             i_wt_valid,
  output logic             o_wt_ready,
  input  logic             i_cfg_reload,
  output logic [PIX_W-1:0] o_pixel_data,
  output logic             o_pixel_data_valid,
  output logic             o_row_done,
  output logic             o_frame_done,
  output state_e           o_dbg_state
);
  localparam int COL_W = $clog2(ROW_OUT + 1);
  localparam int ROW_W = $clog2(ROWS_OUT + 1);
  localparam int IDX_W = $clog2(NUM_WTS + 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        wt_idx_q, wt_idx_d;
  logic signed [WT_W-1:0]  wt_q [NUM_WTS];
  logic signed [WT_W-1:0]  wt_d [NUM_WTS];
  logic signed [WT_W-1:0]  bias_q, bias_d;
  logic                    pend_q, pend_d;
  logic                    v1_q, v2_q, v3_q, out_valid_q;
  logic                    accept, in_flight;
  logic signed [ACC_W-1:0] sum3_q, sum3_d;
  logic [ACC_W-1:0]        relu, shifted;
  logic [PIX_W-1:0]        pix_q, pix_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    row_done_q, row_done_d;
  logic                    frame_done_q, frame_done_d;

  logic [WIN_W-1:0]        pix_in  [NUM_CH];
  logic [WIN_W-1:0]        wt_pack [NUM_CH];
  logic signed [ACC_W-1:0] ch_sum  [NUM_CH];

  assign pix_in[0] = i_pixel_data1;
  assign pix_in[1] = i_pixel_data2;
  assign pix_in[2] = i_pixel_data3;

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      wt_pack[ch] = '0;
      for (int p = 0; p < NUM_TAPS; p++) wt_pack[ch][WT_W*p +: WT_W] = wt_q[NUM_TAPS*ch + p];
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_mac
    mac9 u_mac9 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_pix (pix_in[ch]),
      .i_wt  (wt_pack[ch]),
      .o_sum (ch_sum[ch])
    );
  end

  assign accept    = (state_q == ST_RUN) && i_pixel_data_valid;
  // A reload may only take effect once no window can still see the old weights.
  assign in_flight = v1_q | v2_q | v3_q | out_valid_q | i_pixel_data_valid;

  always_comb begin
    state_d  = state_q;
    wt_idx_d = wt_idx_q;
    wt_d     = wt_q;
    bias_d   = bias_q;
    pend_d   = pend_q;
    case (state_q)
      ST_LOAD: begin
        if (i_wt_valid) begin
          if (wt_idx_q == IDX_W'(NUM_WTS)) begin
            bias_d   = i_wt_data;
            wt_idx_d = '0;
            state_d  = ST_RUN;
          end else begin
            wt_d[wt_idx_q] = i_wt_data;
            wt_idx_d       = wt_idx_q + IDX_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (i_cfg_reload) pend_d = 1'b1;
        if (pend_q && !in_flight) begin
          state_d  = ST_LOAD;
          wt_idx_d = '0;
          pend_d   = 1'b0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // S3 adds the bias pre-scaled into the accumulator's fixed-point frame; S4 requantises.
  always_comb begin
    sum3_d  = ch_sum[0] + ch_sum[1] + ch_sum[2] + (ACC_W'(bias_q) <<< SHIFT);
    relu    = sum3_q[ACC_W-1] ? '0 : ACC_W'(sum3_q);
    shifted = relu >> SHIFT;
    pix_d   = '0;
    if (v3_q) pix_d = (|shifted[ACC_W-1:PIX_W]) ? '1 : shifted[PIX_W-1:0];
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    row_done_d   = 1'b0;
    frame_done_d = 1'b0;
    if (v3_q) begin
      if (col_q == COL_W'(ROW_OUT - 1)) begin
        col_d      = '0;
        row_done_d = 1'b1;
        if (row_q == ROW_W'(ROWS_OUT - 1)) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_LOAD;
      wt_idx_q     <= '0;
      for (int i = 0; i < NUM_WTS; i++) wt_q[i] <= '0;
      bias_q       <= '0;
      pend_q       <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      sum3_q       <= '0;
      pix_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wt_idx_q     <= wt_idx_d;
      wt_q         <= wt_d;
      bias_q       <= bias_d;
      pend_q       <= pend_d;
      v1_q         <= accept;
      v2_q         <= v1_q;
      v3_q         <= v2_q;
      out_valid_q  <= v3_q;
      sum3_q       <= sum3_d;
      pix_q        <= pix_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_done_q   <= row_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_wt_ready         = (state_q == ST_LOAD);
  assign o_pixel_data       = pix_q;
  assign o_pixel_data_valid = out_valid_q;
  assign o_row_done         = row_done_q;
  assign o_frame_done       = frame_done_q;
  assign o_dbg_state        = state_q;
endmodule

// File: tb/tb_conv3x3_mac_relu.sv
// Bench for conv3x3_mac_relu: two instances (SHIFT=0 and SHIFT=8) share one stimulus stream
// and are checked against an arithmetic reference model through per-instance expected queues.
module tb_conv3x3_mac_relu;
  import conv_pkg::*;

  localparam int ROW_OUT  = 111;
  localparam int ROWS_OUT = 111;
  localparam int FRAME    = ROW_OUT * ROWS_OUT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [71:0] pd1 = '0, pd2 = '0, pd3 = '0;
  logic        pvalid = 1'b0;
  logic [7:0]  wt_data = '0;
  logic        wt_valid = 1'b0;
  logic        cfg_reload = 1'b0;

  logic [7:0]  pix_o [2];
  logic        vld_o [2];
  logic        rd_o  [2];
  logic        fd_o  [2];
  logic        rdy_o [2];
  state_e      st_o  [2];

  conv3x3_mac_relu #(.SHIFT(0), .ROW_OUT(ROW_OUT), .ROWS_OUT(ROWS_OUT)) u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_pixel_data1(pd1), .i_pixel_data2(pd2), .i_pixel_data3(pd3),
    .i_pixel_data_valid(pvalid), .i_wt_data(wt_data), .i_wt_valid(wt_valid),
    .o_wt_ready(rdy_o[0]), .i_cfg_reload(cfg_reload),
    .o_pixel_data(pix_o[0]), .o_pixel_data_valid(vld_o[0]),
    .o_row_done(rd_o[0]), .o_frame_done(fd_o[0]), .o_dbg_state(st_o[0])
  );

  conv3x3_mac_relu #(.SHIFT(8), .ROW_OUT(ROW_OUT), .ROWS_OUT(ROWS_OUT)) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_pixel_data1(pd1), .i_pixel_data2(pd2), .i_pixel_data3(pd3),
    .i_pixel_data_valid(pvalid), .i_wt_data(wt_data), .i_wt_valid(wt_valid),
    .o_wt_ready(rdy_o[1]), .i_cfg_reload(cfg_reload),
    .o_pixel_data(pix_o[1]), .o_pixel_data_valid(vld_o[1]),
    .o_row_done(rd_o[1]), .o_frame_done(fd_o[1]), .o_dbg_state(st_o[1])
  );

  // ---------------- reference model ----------------
  logic signed [7:0] w_m [27];
  logic signed [7:0] b_m;
  bit                model_run = 1'b0;
  int                shift_of [2] = '{0, 8};

  function automatic int ref_pix(input logic [71:0] c0, c1, c2, input int shift);
    logic [71:0] win [3];
    int acc = 0;
    win[0] = c0; win[1] = c1; win[2] = c2;
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 9; p++)
        acc += int'(win[c][8*p +: 8]) * int'(w_m[9*c + p]);
    acc += int'(b_m) * (1 << shift);
    if (acc < 0) acc = 0;
    acc = acc / (1 << shift);
    if (acc > 255) acc = 255;
    return acc;
  endfunction

  function automatic logic [71:0] rnd_win();
    logic [95:0] r = {$urandom(), $urandom(), $urandom()};
    return r[71:0];
  endfunction

  function automatic logic [71:0] flat(input logic [7:0] v);
    return {9{v}};
  endfunction

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [2][$];
  int out_cnt [2] = '{0, 0};
  int rd_cnt  [2] = '{0, 0};
  int fd_cnt  [2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_sb
    always @(negedge clk) begin
      logic [31:0] e;
      if (rd_o[g]) rd_cnt[g]++;
      if (fd_o[g]) fd_cnt[g]++;
      if (vld_o[g]) begin
        if (exp_q[g].size() == 0) begin
          check($sformatf("unexpected_out%0d", g), 32'(vld_o[g]), 32'd0);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("pixel%0d_n%0d", g, out_cnt[g]), 32'(pix_o[g]), 32'(e[7:0]));
          check($sformatf("latency%0d", g), 32'(cyc - int'(e[31:8])), 32'd4);
          check($sformatf("row_done%0d", g), 32'(rd_o[g]),
                32'((out_cnt[g] % ROW_OUT) == ROW_OUT - 1));
          check($sformatf("frame_done%0d", g), 32'(fd_o[g]),
                32'((out_cnt[g] % FRAME) == FRAME - 1));
          out_cnt[g]++;
        end
      end else if (rd_o[g] || fd_o[g]) begin
        check($sformatf("stray_done%0d", g), 32'({rd_o[g], fd_o[g]}), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      pvalid = 1'b0; wt_valid = 1'b0; cfg_reload = 1'b0;
    end
  endtask

  task automatic send(input logic [71:0] a, b, c);
    tick();
    pd1 = a; pd2 = b; pd3 = c; pvalid = 1'b1;
    wt_valid = 1'b0; cfg_reload = 1'b0;
    if (model_run)
      for (int g = 0; g < 2; g++)
        exp_q[g].push_back({24'(cyc), 8'(ref_pix(a, b, c, shift_of[g]))});
  endtask

  task automatic send_rnd();
    send(rnd_win(), rnd_win(), rnd_win());
  endtask

  // Loads w_m/b_m with random gaps; windows and reload pulses in LOAD must be ignored.
  task automatic load_weights();
    for (int i = 0; i < 28; i++) begin
      repeat ($urandom_range(0, 1)) begin
        tick();
        wt_valid = 1'b0; pvalid = 1'($urandom_range(0, 1)); pd1 = rnd_win();
        cfg_reload = 1'($urandom_range(0, 1));
      end
      tick();
      wt_valid = 1'b1; wt_data = (i < 27) ? w_m[i] : b_m;
      pvalid = 1'($urandom_range(0, 1)); pd2 = rnd_win(); cfg_reload = 1'b0;
    end
    idle(1);
    model_run = 1'b1;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("ready_low_after_load%0d", g), 32'(rdy_o[g]), 32'd0);
      check($sformatf("run_after_load%0d", g), 32'(st_o[g]), 32'(ST_RUN));
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(rdy_o[0] && rdy_o[1]) && n < 40) begin
      tick();
      n++;
    end
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reload_ready%0d", g), 32'(rdy_o[g]), 32'd1);
      check($sformatf("drained_before_load%0d", g), 32'(exp_q[g].size()), 32'd0);
    end
    model_run = 1'b0;
  endtask

  task automatic reload();
    tick();
    pvalid = 1'b0; wt_valid = 1'b0; cfg_reload = 1'b1;
    tick();
    cfg_reload = 1'b0;
    wait_ready();
  endtask

  task automatic set_weights(input int w, input int b);
    for (int i = 0; i < 27; i++) w_m[i] = 8'(w);
    b_m = 8'(b);
  endtask

  task automatic rand_weights(input int lim);
    for (int i = 0; i < 27; i++) w_m[i] = 8'($urandom_range(0, 2 * lim) - lim);
    b_m = 8'($urandom_range(0, 255));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) tick();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_ready%0d", g), 32'(rdy_o[g]), 32'd1);
      check($sformatf("rst_valid%0d", g), 32'(vld_o[g]), 32'd0);
      check($sformatf("rst_pixel%0d", g), 32'(pix_o[g]), 32'd0);
      check($sformatf("rst_row_done%0d", g), 32'(rd_o[g]), 32'd0);
      check($sformatf("rst_frame_done%0d", g), 32'(fd_o[g]), 32'd0);
      check($sformatf("rst_state%0d", g), 32'(st_o[g]), 32'(ST_LOAD));
    end
    rst = 1'b0;

    // Windows in LOAD produce nothing.
    repeat (3) send_rnd();
    idle(6);

    // All-ones weights and pixels: 27.
    set_weights(1, 0);
    load_weights();
    idle(3);
    for (int g = 0; g < 2; g++)
      check($sformatf("reload_in_load_ignored%0d", g), 32'(rdy_o[g]), 32'd0);
    send(flat(8'd1), flat(8'd1), flat(8'd1));
    idle(6);
    // Saturation: 6885.
    send(flat(8'd255), flat(8'd255), flat(8'd255));
    idle(6);

    // Negative sum clamps to 0; bias alone gives 5.
    set_weights(-1, 5);
    reload();
    load_weights();
    send(flat(8'd1), flat(8'd1), flat(8'd1));
    send(flat(8'd0), flat(8'd0), flat(8'd0));
    idle(6);

    // 2700: saturates unshifted, 10 after >>8.
    set_weights(1, 0);
    reload();
    load_weights();
    send(flat(8'd100), flat(8'd100), flat(8'd100));
    idle(6);

    // Random weights with bursty random windows.
    for (int r = 0; r < 4; r++) begin
      rand_weights((r % 2 == 0) ? 4 : 128);
      reload();
      load_weights();
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        send_rnd();
      end
      idle(6);
    end

    // Reload requested mid-stream; stray weight beats in RUN are ignored.
    rand_weights(8);
    reload();
    load_weights();
    for (int i = 0; i < 20; i++) begin
      send_rnd();
      wt_valid = 1'b1; wt_data = 8'($urandom_range(0, 255));
      if (i == 5) cfg_reload = 1'b1;
      if (i > 6) check("ready_held_while_streaming", 32'(rdy_o[0]), 32'd0);
    end
    idle(1);
    wait_ready();
    rand_weights(8);
    load_weights();
    repeat (10) send_rnd();

    // Reset with windows in flight: they must vanish.
    tick();
    pvalid = 1'b0; rst = 1'b1;
    #6;
    for (int g = 0; g < 2; g++) begin
      exp_q[g].delete();
      out_cnt[g] = 0;
    end
    model_run = 1'b0;
    tick();
    for (int g = 0; g < 2; g++) begin
      check($sformatf("midrst_ready%0d", g), 32'(rdy_o[g]), 32'd1);
      check($sformatf("midrst_valid%0d", g), 32'(vld_o[g]), 32'd0);
      check($sformatf("midrst_state%0d", g), 32'(st_o[g]), 32'(ST_LOAD));
    end
    rst = 1'b0;
    idle(8);

    // Full frame back-to-back.
    rand_weights(6);
    load_weights();
    for (int g = 0; g < 2; g++) begin
      rd_cnt[g] = 0;
      fd_cnt[g] = 0;
    end
    repeat (FRAME) send_rnd();
    idle(8);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("frame_outputs%0d", g), 32'(out_cnt[g]), 32'(FRAME));
      check($sformatf("row_done_count%0d", g), 32'(rd_cnt[g]), 32'(ROWS_OUT));
      check($sformatf("frame_done_count%0d", g), 32'(fd_cnt[g]), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
